// File: rtl/sdram_soc_arbiter_if.sv
// Bundle between the SoC requesters, the round-robin arbiter and the SDRAM controller SoC port.
// The master modport is the arbiter's view; the slave modport is the requesters plus controller.
interface sdram_soc_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 23
);
    logic [NUM_REQ-1:0]            req_valid_port;
    logic [NUM_REQ-1:0]            req_we_port;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_port;
    logic [NUM_REQ*32-1:0]         req_wr_data_port;
    logic [NUM_REQ*4-1:0]          req_wr_mask_port;
    logic [NUM_REQ-1:0]            req_ack_port;
    logic [NUM_REQ-1:0]            req_done_port;
    logic [31:0]                   req_rd_data_port;
    logic [NUM_REQ-1:0]            req_error_port;

    logic                          ctrl_busy_port;
    logic                          ctrl_ready_port;
    logic [ADDR_WIDTH-1:0]         ctrl_addr_port;
    logic [31:0]                   ctrl_wr_data_port;
    logic [3:0]                    ctrl_wr_mask_port;
    logic                          ctrl_wr_en_port;
    logic                          ctrl_rd_en_port;
    logic [31:0]                   ctrl_rd_data_port;

    modport master (
        input  req_valid_port, req_we_port, req_addr_port, req_wr_data_port, req_wr_mask_port,
        output req_ack_port, req_done_port, req_rd_data_port, req_error_port,
        input  ctrl_busy_port, ctrl_ready_port, ctrl_rd_data_port,
        output ctrl_addr_port, ctrl_wr_data_port, ctrl_wr_mask_port, ctrl_wr_en_port, ctrl_rd_en_port
    );

    modport slave (
        output req_valid_port, req_we_port, req_addr_port, req_wr_data_port, req_wr_mask_port,
        input  req_ack_port, req_done_port, req_rd_data_port, req_error_port,
        output ctrl_busy_port, ctrl_ready_port, ctrl_rd_data_port,
        input  ctrl_addr_port, ctrl_wr_data_port, ctrl_wr_mask_port, ctrl_wr_en_port, ctrl_rd_en_port
    );
endinterface

// File: rtl/sdram_soc_arbiter.sv
// Round-robin arbiter sharing the sdram_controller SoC port among NUM_REQ requesters.
// One command in flight at a time; a watchdog aborts commands the controller never completes.
module sdram_soc_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_WIDTH     = 23,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset_port,
    sdram_soc_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                 state_q,   state_d;
    logic [IW-1:0]          rr_ptr_q,  rr_ptr_d;
    logic [IW-1:0]          gnt_q,     gnt_d;
    logic                   we_q,      we_d;
    logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
    logic [31:0]            wr_data_q, wr_data_d;
    logic [3:0]             wr_mask_q, wr_mask_d;
    logic [CW-1:0]          cnt_q,     cnt_d;
    logic [NUM_REQ-1:0]     ack_q,     ack_d;
    logic [NUM_REQ-1:0]     done_q,    done_d;
    logic [NUM_REQ-1:0]     err_q,     err_d;
    logic [31:0]            rd_data_q, rd_data_d;
    logic                   wr_en_q,   wr_en_d;
    logic                   rd_en_q,   rd_en_d;
    logic [IW-1:0]          pick_idx;

    // First valid requester at or after ptr, scanning upward with wrap.
    function automatic logic [IW-1:0] pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IW-1:0]      ptr);
        logic [IW-1:0] r;
        int            pos;
        r = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (valid[IW'(pos)]) r = IW'(pos);
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (int'(i) >= NUM_REQ - 1) return '0;
        return i + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_mask_d = wr_mask_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        ack_d     = '0;
        done_d    = '0;
        err_d     = '0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        pick_idx  = pick(bus.req_valid_port, rr_ptr_q);

        case (state_q)
            S_IDLE: begin
                // Ack and strobe are registered here so they appear together in ISSUE.
                if (!bus.ctrl_busy_port && (|bus.req_valid_port)) begin
                    gnt_d     = pick_idx;
                    we_d      = bus.req_we_port[pick_idx];
                    addr_d    = bus.req_addr_port[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_data_d = bus.req_wr_data_port[int'(pick_idx)*32 +: 32];
                    wr_mask_d = bus.req_wr_mask_port[int'(pick_idx)*4 +: 4];
                    ack_d     = onehot(pick_idx);
                    wr_en_d   = bus.req_we_port[pick_idx];
                    rd_en_d   = !bus.req_we_port[pick_idx];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ctrl_ready_port) begin
                    rd_data_d = bus.ctrl_rd_data_port;
                    done_d    = onehot(gnt_q);
                    rr_ptr_d  = next_idx(gnt_q);
                    state_d   = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = onehot(gnt_q);
                    rr_ptr_d  = next_idx(gnt_q);
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every register clears on reset, so an orphaned WAIT is simply forgotten.
    always_ff @(posedge clk) begin
        if (reset_port) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            wr_mask_q <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            done_q    <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_mask_q <= wr_mask_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign bus.req_ack_port      = ack_q;
    assign bus.req_done_port     = done_q;
    assign bus.req_error_port    = err_q;
    assign bus.req_rd_data_port  = rd_data_q;
    assign bus.ctrl_addr_port    = addr_q;
    assign bus.ctrl_wr_data_port = wr_data_q;
    assign bus.ctrl_wr_mask_port = wr_mask_q;
    assign bus.ctrl_wr_en_port   = wr_en_q;
    assign bus.ctrl_rd_en_port   = rd_en_q;

    a_one_strobe: assert property (@(posedge clk) disable iff (reset_port) !(wr_en_q && rd_en_q));
    a_one_ack:    assert property (@(posedge clk) disable iff (reset_port) $onehot0(ack_q));
endmodule

// File: tb/tb_sdram_soc_arbiter.sv
// Directed bench for sdram_soc_arbiter: expected commands/completions are queued by the
// stimulus and checked by an independent monitor; a small controller model answers strobes.
module tb_sdram_soc_arbiter;
    localparam int NR = 3;
    localparam int AW = 23;

    typedef struct {
        logic [NR-1:0] ack;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic [3:0]    mask;
    } cmd_t;

    typedef struct {
        logic [NR-1:0] done;
        logic [NR-1:0] err;
        logic [31:0]   rd;
        bit            chk_rd;
    } cmp_t;

    bit   clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_fail;
    cmd_t cmd_q[$];
    cmp_t cmp_q[$];

    logic        model_ready;
    logic        stim_ready;
    int          ctl_lat;
    bit          ctl_never;
    logic [31:0] ctl_rdata;
    int          reload[NR];
    int          pass_n[NR];

    sdram_soc_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) bus ();

    sdram_soc_arbiter #(
        .NUM_REQ       (NR),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .reset_port(rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.ctrl_ready_port = model_ready | stim_ready;

    // Controller model: ready (with data = ctl_rdata ^ addr) ctl_lat cycles after a strobe.
    initial begin
        logic [AW-1:0] a;
        int            lat;
        model_ready           = 1'b0;
        bus.ctrl_rd_data_port = '0;
        forever begin
            @(negedge clk);
            if ((bus.ctrl_wr_en_port || bus.ctrl_rd_en_port) && !ctl_never) begin
                a   = bus.ctrl_addr_port;
                lat = ctl_lat;
                repeat (lat) @(posedge clk);
                #1;
                model_ready           = 1'b1;
                bus.ctrl_rd_data_port = ctl_rdata ^ {9'b0, a};
                @(posedge clk);
                #1;
                model_ready           = 1'b0;
                bus.ctrl_rd_data_port = '0;
            end
        end
    end

    // Monitor: every ack/strobe and every done/error pops one expectation.
    always @(negedge clk) begin
        cmd_t c;
        cmp_t p;
        if ((|bus.req_ack_port) || bus.ctrl_wr_en_port || bus.ctrl_rd_en_port) begin
            n_vec++;
            if (cmd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_cmd @%0d: ack=%b wr=%b rd=%b, none expected", cyc,
                         bus.req_ack_port, bus.ctrl_wr_en_port, bus.ctrl_rd_en_port);
            end else begin
                c = cmd_q.pop_front();
                if ({bus.req_ack_port, bus.ctrl_wr_en_port, bus.ctrl_rd_en_port, bus.ctrl_addr_port,
                     bus.ctrl_wr_data_port, bus.ctrl_wr_mask_port} !==
                    {c.ack, c.we, !c.we, c.addr, c.wd, c.mask}) begin
                    n_fail++;
                    $display("FAIL cmd @%0d: got ack=%b wr=%b rd=%b addr=%h wd=%h m=%h, expected ack=%b wr=%b rd=%b addr=%h wd=%h m=%h",
                             cyc, bus.req_ack_port, bus.ctrl_wr_en_port, bus.ctrl_rd_en_port,
                             bus.ctrl_addr_port, bus.ctrl_wr_data_port, bus.ctrl_wr_mask_port,
                             c.ack, c.we, !c.we, c.addr, c.wd, c.mask);
                end
            end
        end
        if ((|bus.req_done_port) || (|bus.req_error_port)) begin
            n_vec++;
            if (cmp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_completion @%0d: done=%b err=%b, none expected", cyc,
                         bus.req_done_port, bus.req_error_port);
            end else begin
                p = cmp_q.pop_front();
                if ({bus.req_done_port, bus.req_error_port, p.chk_rd ? bus.req_rd_data_port : 32'h0} !==
                    {p.done, p.err, p.chk_rd ? p.rd : 32'h0}) begin
                    n_fail++;
                    $display("FAIL completion @%0d: got done=%b err=%b rd=%h, expected done=%b err=%b rd=%h",
                             cyc, bus.req_done_port, bus.req_error_port, bus.req_rd_data_port,
                             p.done, p.err, p.rd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [127:0] all_outputs();
        return {26'b0, bus.req_ack_port, bus.req_done_port, bus.req_error_port, bus.req_rd_data_port,
                bus.ctrl_addr_port, bus.ctrl_wr_data_port, bus.ctrl_wr_mask_port,
                bus.ctrl_wr_en_port, bus.ctrl_rd_en_port};
    endfunction

    task automatic push_cmd(input logic [NR-1:0] ack, input logic we, input logic [AW-1:0] addr,
                            input logic [31:0] wd, input logic [3:0] mask);
        cmd_t c;
        c.ack = ack; c.we = we; c.addr = addr; c.wd = wd; c.mask = mask;
        cmd_q.push_back(c);
    endtask

    task automatic push_cmp(input logic [NR-1:0] done, input logic [NR-1:0] err,
                            input logic [31:0] rd, input bit chk_rd);
        cmp_t p;
        p.done = done; p.err = err; p.rd = rd; p.chk_rd = chk_rd;
        cmp_q.push_back(p);
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] mask);
        bus.req_valid_port[i]            = 1'b1;
        bus.req_we_port[i]               = we;
        bus.req_addr_port[i*AW +: AW]    = addr;
        bus.req_wr_data_port[i*32 +: 32] = wd;
        bus.req_wr_mask_port[i*4 +: 4]   = mask;
    endtask

    // Write pattern n of requester i, as used by the round-robin sequence.
    task automatic load_wr(input int i, input int n);
        logic [3:0] m;
        m = 4'h1 << i;
        set_req(i, 1'b1, AW'((i << 12) + n), 32'hA000_0000 + 32'(i << 8) + 32'(n), (n != 0) ? ~m : m);
    endtask

    // One clock; requesters drop or reload their request on ack.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ack_port[i]) begin
                if (reload[i] > 0) begin
                    reload[i]--;
                    pass_n[i]++;
                    load_wr(i, pass_n[i]);
                end else begin
                    bus.req_valid_port[i] = 1'b0;
                end
            end
        end
    endtask

    function automatic bit hit(input int kind);
        case (kind)
            0:       return bus.ctrl_wr_en_port || bus.ctrl_rd_en_port;
            1:       return |bus.req_done_port;
            default: return |bus.req_error_port;
        endcase
    endfunction

    task automatic wait_evt(input int kind, input int budget, input string nm, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            step();
            if (hit(kind)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not finish, vectors=%0d", n_vec);
        $fatal(1, "global timeout");
    end

    initial begin
        int s, at, rel, t0, e, seen;
        n_vec = 0; n_fail = 0;
        rst = 1'b1;
        stim_ready = 1'b0;
        ctl_lat = 3; ctl_never = 1'b0; ctl_rdata = '0;
        bus.req_valid_port = '0; bus.req_we_port = '0; bus.req_addr_port = '0;
        bus.req_wr_data_port = '0; bus.req_wr_mask_port = '0;
        bus.ctrl_busy_port = 1'b0;
        for (int i = 0; i < NR; i++) begin reload[i] = 1; pass_n[i] = 0; load_wr(i, 0); end

        // Reset with all three valid, then round-robin writes 0,1,2,0,1,2.
        push_cmd(3'b001, 1'b1, 23'h000000, 32'hA000_0000, 4'h1);
        push_cmd(3'b010, 1'b1, 23'h001000, 32'hA000_0100, 4'h2);
        push_cmd(3'b100, 1'b1, 23'h002000, 32'hA000_0200, 4'h4);
        push_cmd(3'b001, 1'b1, 23'h000001, 32'hA000_0001, 4'hE);
        push_cmd(3'b010, 1'b1, 23'h001001, 32'hA000_0101, 4'hD);
        push_cmd(3'b100, 1'b1, 23'h002001, 32'hA000_0201, 4'hB);
        for (int k = 0; k < 6; k++) push_cmp(3'b001 << (k % 3), 3'b000, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("reset_outputs_zero", all_outputs(), 128'h0);
        end
        rst = 1'b0;
        rel = cyc;
        wait_evt(0, 5, "first_grant", s);
        chk("first_strobe_cycle", 128'(s), 128'(rel + 1));
        wait_evt(1, 20, "rr_done0", at);
        chk("write_done_latency", 128'(at), 128'(s + 4));
        for (int k = 1; k < 6; k++) wait_evt(1, 20, "rr_done", at);
        chk("rr_cmds_drained", 128'(cmd_q.size()), 128'h0);

        // Single read by req1, ready 8 cycles after the strobe.
        ctl_lat = 8;
        ctl_rdata = 32'hDEAD_1522;   // model XORs in addr 0x00ABCD -> 0xDEADBEEF
        push_cmd(3'b010, 1'b0, 23'h00ABCD, 32'h1111_1111, 4'h5);
        push_cmp(3'b010, 3'b000, 32'hDEAD_BEEF, 1'b1);
        step();
        set_req(1, 1'b0, 23'h00ABCD, 32'h1111_1111, 4'h5);
        t0 = cyc;
        wait_evt(0, 5, "read_ack", s);
        chk("read_ack_cycle", 128'(s), 128'(t0 + 1));
        wait_evt(1, 20, "read_done", at);
        chk("read_done_cycle", 128'(at), 128'(s + 9));
        chk("read_addr_held", 128'(bus.ctrl_addr_port), 128'h00ABCD);

        // Busy gating: req2 waits out 20 busy cycles.
        ctl_lat = 3;
        push_cmd(3'b100, 1'b1, 23'h0004C2, 32'hCAFE_F00D, 4'h9);
        push_cmp(3'b100, 3'b000, 32'h0, 1'b0);
        step();
        bus.ctrl_busy_port = 1'b1;
        set_req(2, 1'b1, 23'h0004C2, 32'hCAFE_F00D, 4'h9);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if ((|bus.req_ack_port) || hit(0)) seen++;
        end
        chk("busy_no_ack", 128'(seen), 128'h0);
        bus.ctrl_busy_port = 1'b0;
        t0 = cyc;
        wait_evt(0, 5, "busy_grant", s);
        chk("busy_ack_cycle", 128'(s), 128'(t0 + 1));
        wait_evt(1, 20, "busy_done", at);

        // Timeout: req0 read never completes, req1 write is granted next.
        ctl_never = 1'b1;
        push_cmd(3'b001, 1'b0, 23'h0000F0, 32'h0, 4'h0);
        push_cmp(3'b000, 3'b001, 32'h0, 1'b0);
        push_cmd(3'b010, 1'b1, 23'h000111, 32'h5555_AAAA, 4'hF);
        push_cmp(3'b010, 3'b000, 32'h0, 1'b0);
        step();
        set_req(0, 1'b0, 23'h0000F0, 32'h0, 4'h0);
        set_req(1, 1'b1, 23'h000111, 32'h5555_AAAA, 4'hF);
        wait_evt(0, 5, "timeout_strobe", s);
        wait_evt(2, 40, "timeout_error", e);
        chk("error_cycle", 128'(e), 128'(s + 17));
        ctl_never = 1'b0;
        wait_evt(0, 5, "after_timeout_grant", at);
        chk("after_timeout_strobe", 128'(at), 128'(e + 1));
        wait_evt(1, 20, "after_timeout_done", at);

        // Reset mid-WAIT, stale ready 2 cycles after release.
        ctl_never = 1'b1;
        push_cmd(3'b100, 1'b0, 23'h000777, 32'h0, 4'h0);
        step();
        set_req(2, 1'b0, 23'h000777, 32'h0, 4'h0);
        wait_evt(0, 5, "orphan_strobe", s);
        repeat (3) step();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("midwait_reset_zero", all_outputs(), 128'h0);
        end
        rst = 1'b0;
        repeat (2) step();
        stim_ready = 1'b1;
        step();
        stim_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (all_outputs() != 128'h0) seen++;
        end
        chk("stale_ready_ignored", 128'(seen), 128'h0);

        // Normal service resumes with rr_ptr back at 0.
        ctl_never = 1'b0;
        ctl_lat = 2;
        ctl_rdata = 32'h1234_5678;
        push_cmd(3'b001, 1'b0, 23'h000040, 32'h0, 4'h0);
        push_cmp(3'b001, 3'b000, 32'h1234_5638, 1'b1);
        push_cmd(3'b100, 1'b0, 23'h000200, 32'h0, 4'h0);
        push_cmp(3'b100, 3'b000, 32'h1234_5478, 1'b1);
        set_req(0, 1'b0, 23'h000040, 32'h0, 4'h0);
        set_req(2, 1'b0, 23'h000200, 32'h0, 4'h0);
        wait_evt(1, 20, "resume_done0", at);
        wait_evt(1, 20, "resume_done2", at);
        repeat (3) step();

        chk("cmd_queue_drained", 128'(cmd_q.size()), 128'h0);
        chk("cmp_queue_drained", 128'(cmp_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_soc_arbiter.md
# sdram_soc_arbiter

Round-robin arbiter that shares the single SoC-side port of `sdram_controller` (23-bit word address, 32-bit data, 4-bit byte mask) among `NUM_REQ` independent requesters, such as CPU instruction fetch, CPU data and a DMA/video engine. It sits between the requesters and the controller, clocked by the controller's clock. Each cycle it grants at most one latched command, issues it to the controller as a one-cycle enable pulse, waits for the controller's `ready`, and routes completion and read data back to the granted requester. A watchdog flags transactions the controller never completes.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters, 2..4.
- `ADDR_WIDTH`, 23: SoC word address width.
- `TIMEOUT_CYCLES`, 4096: maximum cycles in WAIT before abort.

Ports:
- `clk`  in  1  system clock, same clock as `sdram_controller`.
- `reset_port`  in  1  synchronous, active-high reset.
- `req_valid_port`  in  NUM_REQ  per-requester command request; held until ack.
- `req_we_port`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr_port`  in  NUM_REQ*ADDR_WIDTH  flat word addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wr_data_port`  in  NUM_REQ*32  flat write data.
- `req_wr_mask_port`  in  NUM_REQ*4  flat byte masks.
- `req_ack_port`  out  NUM_REQ  one-cycle pulse: command accepted.
- `req_done_port`  out  NUM_REQ  one-cycle pulse: command completed.
- `req_rd_data_port`  out  32  read data, valid while `req_done_port` is high.
- `req_error_port`  out  NUM_REQ  one-cycle pulse: timeout abort.
- `ctrl_busy_port`  in  1  controller busy.
- `ctrl_ready_port`  in  1  controller completion pulse; read data valid in the same cycle.
- `ctrl_addr_port`  out  ADDR_WIDTH  command address.
- `ctrl_wr_data_port`  out  32  command write data.
- `ctrl_wr_mask_port`  out  4  command byte mask.
- `ctrl_wr_en_port`  out  1  one-cycle write strobe.
- `ctrl_rd_en_port`  out  1  one-cycle read strobe.
- `ctrl_rd_data_port`  in  32  controller read data.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE: if `ctrl_busy_port`=0 and any `req_valid_port` bit is set:
  - choose the granted index g as the first valid requester at or after `rr_ptr`, scanning upward with wrap.
  - latch g, we, addr, wr_data and mask from the inputs in this cycle.
  - go to ISSUE.
- ISSUE (one cycle):
  - `req_ack_port[g]`=1.
  - exactly one of `ctrl_wr_en_port`/`ctrl_rd_en_port`=1.
  - `ctrl_addr/wr_data/wr_mask` driven from the latched values.
  - go to WAIT and clear the watchdog counter.
- WAIT:
  - on `ctrl_ready_port`=1: register `ctrl_rd_data_port` into `req_rd_data_port`, pulse `req_done_port[g]` next cycle, set `rr_ptr` = (g+1) mod NUM_REQ, go to IDLE.
  - if the counter reaches TIMEOUT_CYCLES-1 without ready: pulse `req_error_port[g]` next cycle, advance `rr_ptr` the same way, go to IDLE.
- `ctrl_*` command outputs hold their latched values outside ISSUE. Strobes are 0 outside ISSUE.
- `ctrl_ready_port` is ignored in IDLE and ISSUE (stale completions are discarded).
- The requester must hold `valid` and its fields stable until ack. Values are sampled in the grant cycle only; a later drop of `valid` does not cancel the command.
- A write completion also returns `req_done_port`; `req_rd_data_port` is then don't-care but still registered.
- Reset (any cycle, including mid-WAIT):
  - state IDLE, `rr_ptr`=0, counter 0.
  - all outputs 0.
  - a completion from an orphaned in-flight controller command is discarded per the stale-ready rule.

## Timing
- Grant decided in cycle t (IDLE, busy=0, valid). Ack and strobe are registered and visible in t+1.
- If `ctrl_ready_port` is seen in cycle k, done and data appear in k+1, and the state is IDLE in k+1.
- Earliest next grant decision is k+1; its strobe is in k+2.
- Minimum arbiter overhead: 2 cycles per transaction beyond controller latency.
- Starvation bound: a continuously valid requester is granted within NUM_REQ-1 other transactions.
- Simultaneous requests in one cycle: only one ack. The others stay pending and see no ack.
- Timeout abort at WAIT cycle TIMEOUT_CYCLES; error pulse in the following cycle.

## Test plan
- **Reset:** hold `reset_port`=1 for 3 cycles with all requests valid. Required: all outputs 0 and no strobe. After release, req0 is granted first (`rr_ptr`=0).
- **Single read:** req1 reads addr 0x00ABCD, the controller model asserts ready 8 cycles after `rd_en` with data 0xDEADBEEF. Required: ack[1] one cycle after the grant, `ctrl_addr`=0x00ABCD, `done[1]` one cycle after ready with `req_rd_data`=0xDEADBEEF.
- **Round-robin:** req0, req1 and req2 all valid continuously, each doing writes. Required: grant order 0,1,2,0,1,2, and exactly one strobe per transaction with the matching wr_data and mask.
- **Busy gating:** `ctrl_busy`=1 for 20 cycles while req2 is valid. Required: no ack and no strobe; grant in the first cycle busy=0, ack one cycle later.
- **Timeout:** `TIMEOUT_CYCLES`=16 and the controller never asserts ready on a read by req0. Required: `error[0]` pulse 17 cycles after the strobe cycle and no done; the next grant goes to req1.
- **Reset mid-WAIT:** reset during WAIT, then a stale ready pulse 2 cycles after release. Required: outputs 0 and no done pulse; the next request is served normally.
